// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and control types for the pipeline control slice.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // One bundle of every pipeline-register control the unit drives.
  typedef struct packed {
    logic fStall;
    logic dStall;
    logic dBubble;
    logic eBubble;
    logic mBubble;
    logic wStall;
    logic setCc;
  } ctrl_t;

  // Idle: the front end is held and the back stages are flushed with bubbles.
  localparam ctrl_t CTRL_IDLE   = '{fStall: 1'b1, dStall: 1'b0, dBubble: 1'b1, eBubble: 1'b1,
                                    mBubble: 1'b1, wStall: 1'b0, setCc: 1'b0};
  // Halted: everything frozen so the faulting instruction stays visible in W.
  localparam ctrl_t CTRL_HALTED = '{fStall: 1'b1, dStall: 1'b1, dBubble: 1'b0, eBubble: 1'b1,
                                    mBubble: 1'b1, wStall: 1'b1, setCc: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-register bus: hazard inputs from the stages, controls back to them.
interface pipe_ctrl_if;
  logic [3:0] D_icode;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic       e_Cnd;
  logic [3:0] M_icode;
  logic [1:0] m_stat;
  logic [1:0] W_stat;
  logic [3:0] W_icode;
  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;
  logic       set_cc_en;

  // Pipeline side: reports stage contents, consumes the controls.
  modport master (
    output D_icode, E_icode, E_dstM, d_srcA, d_srcB, e_Cnd, M_icode, m_stat, W_stat, W_icode,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en
  );

  // Control-unit side.
  modport slave (
    input  D_icode, E_icode, E_dstM, d_srcA, d_srcB, e_Cnd, M_icode, m_stat, W_stat, W_icode,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational detection of load-use, return and branch-mispredict hazards.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  output logic       loaduse,
  output logic       ret,
  output logic       mispred
);

  // A load in E whose destination is read by the instruction in D; RNONE never matches.
  always_comb begin
    loaduse = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret     = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    mispred = (E_icode == IJXX) && !e_Cnd;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: run/halt FSM, per-stage stall/bubble muxing, saturating counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  pipe_ctrl_if.slave       pipe,
  output logic             running,
  output logic             halted,
  output logic [1:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != CNT_MAX)) return cnt + CNT_ONE;
    return cnt;
  endfunction

  state_t state;
  state_t nextState;
  ctrl_t  ctrl;
  logic   loaduse;
  logic   ret;
  logic   mispred;
  logic   excM;
  logic   excW;

  hazard_detect uHazard (
    .D_icode (pipe.D_icode),
    .E_icode (pipe.E_icode),
    .E_dstM  (pipe.E_dstM),
    .d_srcA  (pipe.d_srcA),
    .d_srcB  (pipe.d_srcB),
    .e_Cnd   (pipe.e_Cnd),
    .M_icode (pipe.M_icode),
    .loaduse (loaduse),
    .ret     (ret),
    .mispred (mispred)
  );

  assign excM = (pipe.m_stat != SAOK);
  assign excW = (pipe.W_stat != SAOK);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state and control muxing; load-use takes priority over ret in decode.
  always_comb begin
    nextState = state;
    ctrl      = CTRL_IDLE;
    case (state)
      IDLE: begin
        if (start) nextState = RUN;
      end
      RUN: begin
        ctrl.fStall  = loaduse | ret;
        ctrl.dStall  = loaduse;
        ctrl.dBubble = mispred | (ret & ~loaduse);
        ctrl.eBubble = mispred | loaduse;
        ctrl.mBubble = excM | excW;
        ctrl.wStall  = excW;
        ctrl.setCc   = (pipe.E_icode == IOPQ) & ~excM & ~excW;
        if (excW) nextState = HALTED;
      end
      HALTED: begin
        ctrl = CTRL_HALTED;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (rst) ctrl = CTRL_IDLE;
  end

  assign pipe.F_stall   = ctrl.fStall;
  assign pipe.D_stall   = ctrl.dStall;
  assign pipe.D_bubble  = ctrl.dBubble;
  assign pipe.E_bubble  = ctrl.eBubble;
  assign pipe.M_bubble  = ctrl.mBubble;
  assign pipe.W_stall   = ctrl.wStall;
  assign pipe.set_cc_en = ctrl.setCc;

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

  // Capture the write-back status that caused the halt.
  always_ff @(posedge clk) begin
    if (rst)                        final_stat <= SAOK;
    else if ((state == RUN) && excW) final_stat <= pipe.W_stat;
  end

  // Performance counters advance only while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else if (state == RUN) begin
      cycle_cnt  <= satInc(cycle_cnt, 1'b1);
      retire_cnt <= satInc(retire_cnt, !excW && (pipe.W_icode != INOP));
      bubble_cnt <= satInc(bubble_cnt, ctrl.dBubble | ctrl.eBubble);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected controls queued at drive time, popped at negedge.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam logic [6:0] C_IDLE = 7'b1011100;
  localparam logic [6:0] C_HALT = 7'b1101110;
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1101000;
  localparam logic [6:0] C_RET  = 7'b1010000;

  typedef struct packed {
    logic [3:0] dIc, eIc, mIc, wIc, dstM, srcA, srcB;
    logic       cnd;
    logic [1:0] mSt, wSt;
  } stim_t;

  typedef struct packed {
    logic [6:0] ctrl;
    logic       running;
    logic       halted;
  } exp_t;

  localparam stim_t DEF = '{INOP, INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, rst4, start4;
  logic        running, halted, running4, halted4;
  logic [1:0]  final_stat, final_stat4;
  logic [31:0] cycle_cnt, retire_cnt, bubble_cnt;
  logic [3:0]  cycle_cnt4, retire_cnt4, bubble_cnt4;
  logic [6:0]  ctrlVec, ctrlVec4;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  pipe_ctrl_if pipe ();
  pipe_ctrl_if pipe4 ();

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pipe(pipe),
    .running(running), .halted(halted), .final_stat(final_stat),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .pipe(pipe4),
    .running(running4), .halted(halted4), .final_stat(final_stat4),
    .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4), .bubble_cnt(bubble_cnt4)
  );

  assign ctrlVec  = {pipe.F_stall, pipe.D_stall, pipe.D_bubble, pipe.E_bubble,
                     pipe.M_bubble, pipe.W_stall, pipe.set_cc_en};
  assign ctrlVec4 = {pipe4.F_stall, pipe4.D_stall, pipe4.D_bubble, pipe4.E_bubble,
                     pipe4.M_bubble, pipe4.W_stall, pipe4.set_cc_en};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stage contents and queue the controls they must produce.
  task automatic drive(input stim_t s, input logic [6:0] c, input logic r, input logic h);
    pipe.D_icode = s.dIc;  pipe.E_icode = s.eIc;  pipe.M_icode = s.mIc;
    pipe.W_icode = s.wIc;  pipe.E_dstM  = s.dstM; pipe.d_srcA  = s.srcA;
    pipe.d_srcB  = s.srcB; pipe.e_Cnd   = s.cnd;  pipe.m_stat  = s.mSt;
    pipe.W_stat  = s.wSt;
    sbq.push_back('{c, r, h});
  endtask

  task automatic test_reset();
    exp_t  e;
    stim_t s;
    s = '{INOP, IJXX, INOP, IOPQ, 4'd3, 4'd3, RNONE, 1'b0, SADR, SADR};
    for (int i = 0; i < 3; i++) begin
      rst = (i == 0);
      drive((i == 0) ? DEF : s, C_IDLE, 1'b0, 1'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL reset[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({cycle_cnt, retire_cnt, bubble_cnt, final_stat} !== {96'd0, SAOK}) begin
      errors++;
      $display("FAIL reset_counters: cyc=%0d ret=%0d bub=%0d stat=%0d, required 0/0/0/0",
               cycle_cnt, retire_cnt, bubble_cnt, final_stat);
    end
    step();
  endtask

  task automatic test_start();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      start = (i == 0);
      drive(DEF, (i == 0) ? C_IDLE : C_NONE, (i == 1), 1'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL start[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_loaduse();
    exp_t        e;
    stim_t       rows [4];
    logic [6:0]  want [4];
    logic [31:0] b0;
    rows = '{'{INOP, IMRMOVQ, INOP, INOP, 4'd3, RNONE, 4'd3, 1'b0, SAOK, SAOK},
             '{INOP, IPOPQ, INOP, INOP, 4'd5, 4'd5, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, IMRMOVQ, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, IRRMOVQ, INOP, INOP, 4'd3, RNONE, 4'd3, 1'b0, SAOK, SAOK}};
    want = '{C_LU, C_LU, C_NONE, C_NONE};
    b0 = '0;
    for (int i = 0; i < 4; i++) begin
      drive(rows[i], want[i], 1'b1, 1'b0);
      @(negedge clk);
      e = sbq.pop_front();
      if (i == 0) begin
        b0 = bubble_cnt;
        checks++;
        if (cycle_cnt !== 32'd1) begin
          errors++;
          $display("FAIL first_run_cycle: cycle_cnt = %0d, required 1", cycle_cnt);
        end
      end
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL loaduse[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (bubble_cnt !== b0 + 32'd2) begin
      errors++;
      $display("FAIL loaduse_bubbles: bubble_cnt = %0d, required %0d", bubble_cnt, b0 + 32'd2);
    end
    step();
  endtask

  task automatic test_ret();
    exp_t        e;
    stim_t       rows [4];
    logic [6:0]  want [4];
    logic [31:0] b0;
    rows = '{'{IRET, INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, IRET, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, INOP, IRET, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, IMRMOVQ, IRET, INOP, 4'd3, 4'd3, RNONE, 1'b0, SAOK, SAOK}};
    want = '{C_RET, C_RET, C_RET, C_LU};
    b0 = '0;
    for (int i = 0; i < 4; i++) begin
      drive(rows[i], want[i], 1'b1, 1'b0);
      @(negedge clk);
      e = sbq.pop_front();
      if (i == 0) b0 = bubble_cnt;
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL ret[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    drive(DEF, C_NONE, 1'b1, 1'b0);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (bubble_cnt !== b0 + 32'd4) begin
      errors++;
      $display("FAIL ret_bubbles: bubble_cnt = %0d, required %0d", bubble_cnt, b0 + 32'd4);
    end
    step();
  endtask

  task automatic test_mispred();
    exp_t       e;
    stim_t      rows [4];
    logic [6:0] want [4];
    rows = '{'{INOP, IJXX, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, IJXX, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK},
             '{IRET, IJXX, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK},
             '{INOP, IOPQ, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK}};
    want = '{7'b0011000, C_NONE, 7'b1011000, 7'b0000001};
    for (int i = 0; i < 4; i++) begin
      drive(rows[i], want[i], 1'b1, 1'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL mispred[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
  endtask

  task automatic test_exception();
    exp_t        e;
    stim_t       rows [4];
    logic [6:0]  want [4];
    logic [95:0] snap;
    rows = '{'{INOP, IOPQ, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SADR, SAOK},
             '{INOP, IOPQ, INOP, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SADR},
             DEF,
             '{IRET, IJXX, INOP, IOPQ, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK}};
    want = '{7'b0000100, 7'b0000110, C_HALT, C_HALT};
    snap = '0;
    for (int i = 0; i < 4; i++) begin
      start = (i == 3);
      drive(rows[i], want[i], (i < 2), (i >= 2));
      @(negedge clk);
      e = sbq.pop_front();
      if (i == 2) begin
        snap = {cycle_cnt, retire_cnt, bubble_cnt};
        checks++;
        if (final_stat !== SADR) begin
          errors++;
          $display("FAIL final_stat_adr: final_stat = %0d, required %0d", final_stat, SADR);
        end
      end
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL exception[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({cycle_cnt, retire_cnt, bubble_cnt, final_stat, halted} !== {snap, SADR, 1'b1}) begin
      errors++;
      $display("FAIL halted_frozen: cnt=%h stat=%0d halted=%b, required cnt=%h stat=2 halted=1",
               {cycle_cnt, retire_cnt, bubble_cnt}, final_stat, halted, snap);
    end
    step();
  endtask

  // Asserts rst for one edge from whatever state the DUT is in and checks the cleared state.
  task automatic test_reset_state(input int tag);
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({ctrlVec, running, halted, final_stat, cycle_cnt, retire_cnt, bubble_cnt} !==
        {C_IDLE, 1'b0, 1'b0, SAOK, 96'd0}) begin
      errors++;
      $display("FAIL reset_from_%0d: ctrl=%b run=%b halt=%b stat=%0d cyc=%0d ret=%0d bub=%0d, required %b/0/0/0/0/0/0",
               tag, ctrlVec, running, halted, final_stat, cycle_cnt, retire_cnt, bubble_cnt, C_IDLE);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_retire();
    exp_t       e;
    stim_t      s;
    logic [3:0] wIcs [5];
    wIcs = '{IRRMOVQ, INOP, IOPQ, INOP, IHALT};
    drive(DEF, C_IDLE, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    e = sbq.pop_front();
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s = DEF;
      s.wIc = wIcs[i];
      s.wSt = (i == 4) ? SHLT : SAOK;
      drive(s, (i == 4) ? 7'b0000110 : C_NONE, 1'b1, 1'b0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL retire[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    drive(DEF, C_HALT, 1'b0, 1'b1);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if ({halted, final_stat, cycle_cnt, retire_cnt, bubble_cnt} !==
        {1'b1, SHLT, 32'd5, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL retire_counts: halt=%b stat=%0d cyc=%0d ret=%0d bub=%0d, required 1/1/5/2/0",
               halted, final_stat, cycle_cnt, retire_cnt, bubble_cnt);
    end
    step();
  endtask

  task automatic test_start_excw();
    exp_t  e;
    stim_t s;
    s = DEF;
    s.wSt = SADR;
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      case (i)
        0:       drive(s, C_IDLE, 1'b0, 1'b0);
        1:       drive(s, 7'b0000110, 1'b1, 1'b0);
        default: drive(DEF, C_HALT, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if ({ctrlVec, running, halted} !== {e.ctrl, e.running, e.halted}) begin
        errors++;
        $display("FAIL start_excw[%0d]: ctrl/run/halt = %b/%b/%b, required %b/%b/%b",
                 i, ctrlVec, running, halted, e.ctrl, e.running, e.halted);
      end
      step();
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({cycle_cnt, final_stat} !== {32'd1, SADR}) begin
      errors++;
      $display("FAIL start_excw_count: cyc=%0d stat=%0d, required 1/2", cycle_cnt, final_stat);
    end
    step();
  endtask

  task automatic test_mid_run_reset();
    stim_t s;
    start = 1'b1;
    step();
    start = 1'b0;
    s = '{INOP, IMRMOVQ, INOP, IOPQ, 4'd3, 4'd3, RNONE, 1'b0, SAOK, SAOK};
    pipe.E_icode = s.eIc; pipe.E_dstM = s.dstM; pipe.d_srcA = s.srcA; pipe.W_icode = s.wIc;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({running, cycle_cnt, retire_cnt, bubble_cnt} !== {1'b1, 32'd3, 32'd3, 32'd3}) begin
      errors++;
      $display("FAIL mid_run: run=%b cyc=%0d ret=%0d bub=%0d, required 1/3/3/3",
               running, cycle_cnt, retire_cnt, bubble_cnt);
    end
    test_reset_state(1);
    drive(DEF, C_IDLE, 1'b0, 1'b0);
    void'(sbq.pop_front());
  endtask

  task automatic test_saturation();
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    repeat (20) step();
    @(negedge clk);
    checks++;
    if ({running4, halted4, final_stat4, cycle_cnt4, retire_cnt4, bubble_cnt4, ctrlVec4} !==
        {1'b1, 1'b0, SAOK, 4'd15, 4'd15, 4'd0, C_NONE}) begin
      errors++;
      $display("FAIL saturate: run=%b halt=%b stat=%0d cyc=%0d ret=%0d bub=%0d ctrl=%b, required 1/0/0/15/15/0/%b",
               running4, halted4, final_stat4, cycle_cnt4, retire_cnt4, bubble_cnt4, ctrlVec4, C_NONE);
    end
    rst4 = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({running4, cycle_cnt4, retire_cnt4, ctrlVec4} !== {1'b0, 4'd0, 4'd0, C_IDLE}) begin
      errors++;
      $display("FAIL saturate_reset: run=%b cyc=%0d ret=%0d ctrl=%b, required 0/0/0/%b",
               running4, cycle_cnt4, retire_cnt4, ctrlVec4, C_IDLE);
    end
    step();
    rst4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rst4 = 1'b1;
    start4 = 1'b0;
    pipe4.D_icode = INOP; pipe4.E_icode = INOP; pipe4.M_icode = INOP; pipe4.W_icode = IOPQ;
    pipe4.E_dstM = RNONE; pipe4.d_srcA = RNONE; pipe4.d_srcB = RNONE; pipe4.e_Cnd = 1'b0;
    pipe4.m_stat = SAOK;  pipe4.W_stat = SAOK;
    test_reset();
    test_start();
    test_loaduse();
    test_ret();
    test_mispred();
    test_exception();
    test_reset_state(2);
    test_retire();
    test_reset_state(2);
    test_start_excw();
    test_reset_state(2);
    test_mid_run_reset();
    test_saturation();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. It produces the per-stage stall and bubble controls that the fetch, decode, execute, memory and write-back pipeline registers consume. It also runs a run/halt state machine that starts the pipeline on command and freezes it when an abnormal status reaches write-back. Saturating performance counters report cycles, retired instructions and inserted bubbles.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE
- D_icode  in  4  icode in decode register
- E_icode  in  4  icode in execute register
- E_dstM  in  4  memory destination in execute register
- d_srcA, d_srcB  in  4 each  decode-stage source register IDs
- e_Cnd  in  1  execute-stage branch condition
- M_icode  in  4  icode in memory register
- m_stat  in  2  memory-stage status
- W_stat  in  2  write-back register status
- W_icode  in  4  icode in write-back register
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls
- set_cc_en  out  1  condition-code write enable for the execute stage
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- final_stat  out  2  W_stat captured on entry to HALTED
- cycle_cnt, retire_cnt, bubble_cnt  out  CNT_W each  performance counters

## Operation
- Hazard terms (combinational):
  - loaduse = E_icode in {MRMOVQ, POPQ} && E_dstM != RNONE && E_dstM in {d_srcA, d_srcB}
  - ret = IRET in {D_icode, E_icode, M_icode}
  - mispred = E_icode == IJXX && !e_Cnd
  - excM = m_stat != SAOK
  - excW = W_stat != SAOK
- State IDLE (reset state):
  - Outputs: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0, set_cc_en=0.
  - Hazard terms are ignored. W_stat is ignored.
  - start=1 moves to RUN.
- State RUN, outputs:
  - F_stall = loaduse | ret
  - D_stall = loaduse
  - D_bubble = mispred | (ret & !loaduse)
  - E_bubble = mispred | loaduse
  - M_bubble = excM | excW
  - W_stall = excW
  - set_cc_en = E_icode==IOPQ & !excM & !excW
- RUN transition: excW moves to HALTED and registers final_stat <= W_stat. start is ignored.
- State HALTED:
  - Outputs: F_stall=1, D_stall=1, W_stall=1, M_bubble=1, E_bubble=1, D_bubble=0, set_cc_en=0.
  - Only rst exits this state.
- Counters, all saturating at 2^CNT_W-1 and updated only in RUN:
  - cycle_cnt +1 every cycle.
  - retire_cnt +1 when !excW && W_icode != INOP.
  - bubble_cnt +1 when D_bubble | E_bubble.
- Simultaneous events:
  - loaduse and ret together: loaduse wins in D (D_stall=1, D_bubble=0).
  - mispred and ret together: D_bubble=1, E_bubble=1, F_stall=1.
  - excW in the cycle start is pulsed in IDLE: go to RUN; excW is evaluated from the next cycle.
- rst mid-operation, from any state, at the next edge:
  - state returns to IDLE.
  - counters, final_stat (SAOK) and halted clear.

## Timing
- Stall/bubble/set_cc_en outputs are combinational from the current inputs and the registered state. Pipeline registers act on them at the next rising edge. Latency from a hazard to its control output is zero cycles.
- State, counters and final_stat are registered and update at the rising edge.
- Reset values:
  - state=IDLE, running=0, halted=0, final_stat=SAOK, all counters 0.
  - Control outputs take their IDLE values while rst is held.
- running rises one cycle after the start pulse. halted rises one cycle after the first cycle with excW in RUN.
- Counters read the cycle's values as the edge is taken. The first RUN cycle after start counts as cycle_cnt=1.

## Structure
- Package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - RNONE=4'hF.
  - stat encoding: SAOK=0, SHLT=1, SADR=2, SINS=3.
  - state enum: IDLE, RUN, HALTED.
- One sub-module, hazard_detect: purely combinational. Outputs loaduse, ret, mispred. pipe_ctrl owns the state machine, the output muxing and the counters.

## Test plan
- Reset, then start; E_icode=MRMOVQ, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; bubble_cnt increments by 1.
- D_icode=IRET for 3 consecutive cycles (D, then E, then M) -> F_stall=1 and D_bubble=1 each cycle. Then ret in M together with loaduse -> D_stall=1, D_bubble=0.
- E_icode=IJXX, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_Cnd=1 -> all controls 0.
- E_icode=IOPQ, m_stat=SADR -> set_cc_en=0, M_bubble=1, state stays RUN. Then W_stat=SADR -> W_stall=1; next cycle halted=1, final_stat=2, all counters frozen.
- 5 RUN cycles with W_icode={IRRMOVQ, INOP, IOPQ, INOP, IHALT}, W_stat=SAOK except SHLT on the last cycle -> retire_cnt=2, cycle_cnt=5, then HALTED with final_stat=1.
- rst asserted in HALTED and mid-RUN; and CNT_W=4 held in RUN for 20 cycles -> rst returns state to IDLE with counters at 0; the 4-bit cycle_cnt saturates at 15.
